pu_scheduler: RTL and testbench
===============================

Name: pu_scheduler

Overview:
Layer-level sequencer sitting above an array of N_PU processing-unit controllers. On a start request it configures all enabled PUs and issues one MAC start per tile. It waits for every enabled PU to report MAC completion before issuing the next tile. After the last tile, or on abort or timeout, it terminates the PUs and reports done/error to the host register block.

Parameters:
N_PU, 4, number of PU controllers driven
TILE_W, 16, width of tile count/index
TO_W, 16, width of watchdog counter
TIMEOUT, 16'hFFFF, max cycles allowed in any waiting state before error

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_start  in  1  start-layer pulse; accepted only in IDLE
i_abort  in  1  abort request; level or pulse
i_num_tiles  in  TILE_W  tiles to run; sampled on accepted i_start
i_pu_mask  in  N_PU  enabled PUs; sampled on accepted i_start
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse on layer completion (normal, abort or timeout)
o_error  out  1  sticky watchdog-timeout flag; cleared on next accepted i_start
o_tile_idx  out  TILE_W  index of tile in flight
o_set_param  out  N_PU  per-PU configure request (level)
i_pu_ready  in  N_PU  per-PU ready-for-MAC
o_start_mac  out  N_PU  per-PU one-cycle MAC start
i_mac_done  in  N_PU  per-PU MAC-done pulse/level
o_terminate  out  1  one-cycle terminate broadcast to all PUs

Behaviour:
- Reset (i_reset=1 at a clock edge): state IDLE; all outputs 0; latched mask, count and done bits cleared. Reset mid-operation aborts immediately and asserts no o_terminate.
- States: IDLE, CONFIG, WAIT_READY, ISSUE, WAIT_DONE, TERMINATE, DONE.
- IDLE, when i_start:
  - Latch mask and count, clear o_error and o_tile_idx.
  - If mask==0 or count==0: go to DONE; no PU outputs toggle.
  - Otherwise go to CONFIG. o_set_param rises the cycle after i_start.
- CONFIG:
  - o_set_param[k] = mask[k] & ~seen_ready[k]. Each bit drops the cycle after i_pu_ready[k] is first seen high.
  - When all masked PUs have been seen ready, go to WAIT_READY.
- WAIT_READY: when (i_pu_ready & mask)==mask, go to ISSUE.
- ISSUE: o_start_mac = mask for exactly one cycle; done-collector cleared; go to WAIT_DONE.
- WAIT_DONE:
  - Sticky collector ORs in i_mac_done & mask.
  - Done bits from unmasked PUs are ignored.
  - A done pulse arriving in the same cycle as the collector clear is captured, not lost.
  - When collector == mask:
    - If o_tile_idx == count-1, go to TERMINATE; o_tile_idx is held.
    - Otherwise o_tile_idx increments and the FSM goes to WAIT_READY.
- TERMINATE: o_terminate=1 for one cycle; go to DONE.
- DONE: o_done=1 for one cycle; go to IDLE. o_busy falls in the same cycle as the IDLE entry.
- Watchdog:
  - Counter cleared on entry to CONFIG, WAIT_READY and WAIT_DONE; increments in those states.
  - At count==TIMEOUT: set o_error and go to TERMINATE.
- Abort: i_abort in any non-IDLE state except TERMINATE/DONE goes to TERMINATE next edge. Abort has priority over the watchdog and over normal transitions in the same cycle.
- i_start while busy is ignored. i_abort in IDLE is ignored.
- Arithmetic: o_tile_idx is unsigned and never wraps, since the count-1 comparison ends the layer first. Latched count is never re-read mid-layer.
- Latency, one tile: ISSUE → first o_start_mac same cycle; last i_mac_done → next o_start_mac ≥2 cycles (WAIT_READY, ISSUE).

Decomposition:
- Shared package pu_sched_pkg: state encoding localparams (3-bit, IDLE=0 … DONE=6) and default TIMEOUT.
- One sub-module, pu_done_collector: N_PU-wide sticky OR register with synchronous clear, mask input and all_done output. It is reused for the CONFIG ready-seen tracking as a second instance.

Test Plan:
- mask=4'b1111, count=3, PUs respond ready 2 cycles after set_param and done 5 cycles after start → exactly 3 o_start_mac pulses; o_tile_idx 0,1,2; one o_terminate; then one o_done; o_error=0.
- mask=4'b0101, count=2, PUs 1 and 3 never respond → completes normally; o_set_param/o_start_mac bits 1,3 stay 0.
- PU2 done arrives 40 cycles later than others with TIMEOUT=16'd32 → o_error=1, o_terminate then o_done, o_tile_idx frozen at 0.
- i_abort pulse during WAIT_DONE of tile 1 of count=4 → o_terminate next cycle, o_done following, no further o_start_mac.
- count=0, then mask=0 → o_done 1 cycle after i_start; no o_set_param, o_start_mac or o_terminate activity.
- i_reset asserted in WAIT_DONE; i_start pulsed during busy → all outputs 0 the cycle after reset with no o_terminate; busy-time start has no effect.

Source files
------------

// File: rtl/pu_sched_pkg.sv
// Shared types and defaults for the layer-level PU scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pu_sched_pkg;

    // Scheduler FSM encoding, 3 bits, IDLE=0 through DONE=6.
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_CONFIG     = 3'd1,
        S_WAIT_READY = 3'd2,
        S_ISSUE      = 3'd3,
        S_WAIT_DONE  = 3'd4,
        S_TERMINATE  = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    // Default watchdog limit, in cycles spent in a single waiting state.
    localparam logic [15:0] DEFAULT_TIMEOUT = 16'hFFFF;

    // States in which the watchdog runs.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_CONFIG) || (s == S_WAIT_READY) || (s == S_WAIT_DONE);
    endfunction

endpackage

// File: rtl/pu_done_collector.sv
// Sticky per-PU OR register with synchronous clear, masked by the enabled-PU set.
// Latency: bits register one cycle after input; o_all_done also includes this cycle's input.
// Backpressure: none; an input pulse coinciding with i_clr is loaded, never dropped.
module pu_done_collector #(
    parameter int N_PU = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_clr,
    input  logic [N_PU-1:0] i_bits,
    input  logic [N_PU-1:0] i_mask,
    output logic [N_PU-1:0] o_bits,
    output logic            o_all_done
);

    logic [N_PU-1:0] r_bits;
    logic [N_PU-1:0] w_in;

    assign w_in = i_bits & i_mask;

    // Accumulate masked bits; a clear reloads with the current input so nothing is lost.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bits <= '0;
        end else if (i_clr) begin
            r_bits <= w_in;
        end else begin
            r_bits <= r_bits | w_in;
        end
    end

    assign o_bits     = r_bits;
    assign o_all_done = ((r_bits | w_in) & i_mask) == i_mask;

endmodule

// File: rtl/pu_scheduler.sv
// Layer sequencer: configures enabled PUs, issues one MAC start per tile, terminates and reports done/error.
// Latency: last MAC done -> next start_mac in 2 cycles; zero-work layer -> o_done 1 cycle after i_start.
// Backpressure: waits on per-PU ready/done levels; watchdog or abort forces termination.
module pu_scheduler
    import pu_sched_pkg::*;
#(
    parameter int              N_PU    = 4,
    parameter int              TILE_W  = 16,
    parameter int              TO_W    = 16,
    parameter logic [TO_W-1:0] TIMEOUT = TO_W'(DEFAULT_TIMEOUT)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [TILE_W-1:0] i_num_tiles,
    input  logic [N_PU-1:0]   i_pu_mask,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [TILE_W-1:0] o_tile_idx,
    output logic [N_PU-1:0]   o_set_param,
    input  logic [N_PU-1:0]   i_pu_ready,
    output logic [N_PU-1:0]   o_start_mac,
    input  logic [N_PU-1:0]   i_mac_done,
    output logic              o_terminate
);

    state_t            r_state;
    state_t            w_next;
    logic [N_PU-1:0]   r_mask;
    logic [TILE_W-1:0] r_count;
    logic [TILE_W-1:0] r_tile_idx;
    logic              r_error;
    logic [TO_W-1:0]   r_wdog;

    logic              w_timeout;
    logic              w_wd_hit;
    logic              w_last_tile;
    logic              w_tile_adv;
    logic              w_all_ready;
    logic [N_PU-1:0]   w_seen_ready;
    logic [N_PU-1:0]   w_rdy_bits;
    logic              w_rdy_all;
    logic              w_done_all;
    logic [N_PU-1:0]   w_done_bits_unused;

    // Ready tracking only listens during CONFIG and is wiped while idle.
    assign w_rdy_bits = (r_state == S_CONFIG) ? i_pu_ready : '0;

    pu_done_collector #(.N_PU(N_PU)) u_ready_seen (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clr      (r_state == S_IDLE),
        .i_bits     (w_rdy_bits),
        .i_mask     (r_mask),
        .o_bits     (w_seen_ready),
        .o_all_done (w_rdy_all)
    );

    // Done tracking is cleared on the issue cycle, capturing any same-cycle done.
    pu_done_collector #(.N_PU(N_PU)) u_mac_done (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clr      (r_state == S_ISSUE),
        .i_bits     (i_mac_done),
        .i_mask     (r_mask),
        .o_bits     (w_done_bits_unused),
        .o_all_done (w_done_all)
    );

    assign w_wd_hit    = is_wait_state(r_state) && (r_wdog == TIMEOUT);
    assign w_last_tile = (r_tile_idx == (r_count - TILE_W'(1)));
    assign w_all_ready = (i_pu_ready & r_mask) == r_mask;
    assign w_tile_adv  = (r_state == S_WAIT_DONE) && (w_next == S_WAIT_READY);

    // Next-state: abort beats watchdog beats normal progress.
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = ((i_pu_mask == '0) || (i_num_tiles == '0)) ? S_DONE : S_CONFIG;
                end
            end
            S_CONFIG: begin
                if (i_abort) begin
                    w_next = S_TERMINATE;
                end else if (w_wd_hit) begin
                    w_next    = S_TERMINATE;
                    w_timeout = 1'b1;
                end else if (w_rdy_all) begin
                    w_next = S_WAIT_READY;
                end
            end
            S_WAIT_READY: begin
                if (i_abort) begin
                    w_next = S_TERMINATE;
                end else if (w_wd_hit) begin
                    w_next    = S_TERMINATE;
                    w_timeout = 1'b1;
                end else if (w_all_ready) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next = i_abort ? S_TERMINATE : S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (i_abort) begin
                    w_next = S_TERMINATE;
                end else if (w_wd_hit) begin
                    w_next    = S_TERMINATE;
                    w_timeout = 1'b1;
                end else if (w_done_all) begin
                    w_next = w_last_tile ? S_TERMINATE : S_WAIT_READY;
                end
            end
            S_TERMINATE: w_next = S_DONE;
            S_DONE:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Layer context, tile index, sticky error and watchdog.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mask     <= '0;
            r_count    <= '0;
            r_tile_idx <= '0;
            r_error    <= 1'b0;
            r_wdog     <= '0;
        end else begin
            if ((r_state == S_IDLE) && i_start) begin
                r_mask     <= i_pu_mask;
                r_count    <= i_num_tiles;
                r_tile_idx <= '0;
                r_error    <= 1'b0;
            end else begin
                if (w_timeout) begin
                    r_error <= 1'b1;
                end
                if (w_tile_adv) begin
                    r_tile_idx <= r_tile_idx + TILE_W'(1);
                end
            end
            if (is_wait_state(w_next) && (w_next != r_state)) begin
                r_wdog <= '0;
            end else if (is_wait_state(w_next)) begin
                r_wdog <= r_wdog + TO_W'(1);
            end
        end
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign o_terminate = (r_state == S_TERMINATE);
    assign o_error     = r_error;
    assign o_tile_idx  = r_tile_idx;
    assign o_set_param = (r_state == S_CONFIG) ? (r_mask & ~w_seen_ready) : '0;
    assign o_start_mac = (r_state == S_ISSUE) ? r_mask : '0;

endmodule

// File: tb/tb_pu_scheduler.sv
// Randomized scoreboard bench for pu_scheduler with behavioural PU responders.
// Latency: n/a.
// Backpressure: n/a.
module tb_pu_scheduler;

    localparam int LATE_DLY = 45;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [15:0] num_tiles;
    logic [3:0]  pu_mask, pu_ready, mac_done;
    logic        busy, done, err, term;
    logic [15:0] tile_idx;
    logic [3:0]  set_param, start_mac;

    pu_scheduler #(.N_PU(4), .TILE_W(16), .TO_W(16), .TIMEOUT(16'd32)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_abort     (abort),
        .i_num_tiles (num_tiles),
        .i_pu_mask   (pu_mask),
        .o_busy      (busy),
        .o_done      (done),
        .o_error     (err),
        .o_tile_idx  (tile_idx),
        .o_set_param (set_param),
        .i_pu_ready  (pu_ready),
        .o_start_mac (start_mac),
        .i_mac_done  (mac_done),
        .o_terminate (term)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct { logic [3:0] mask; int idx; } start_t;
    typedef struct { bit err; int nterm; int tile; bit setp; } end_t;
    start_t exp_start[$];
    end_t   exp_end[$];

    logic [3:0] cur_mask = 4'h0;
    int  rdy_dly[4];
    int  done_dly[4];
    int  late_pu   = -1;
    int  late_tile = -1;
    bit  noise_en  = 1'b0;
    bit  prev_err  = 1'b0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Behavioural PUs: ready some cycles after configure, done some cycles after start.
    initial begin
        int rcnt[4];
        bit rarm[4];
        int dcnt[4];
        int tiles[4];
        pu_ready = '0;
        mac_done = '0;
        for (int k = 0; k < 4; k++) begin
            rcnt[k] = 0; rarm[k] = 0; dcnt[k] = -1; tiles[k] = 0;
        end
        forever begin
            @(negedge clk);
            if (rst || done) begin
                for (int k = 0; k < 4; k++) begin
                    rarm[k] = 0; dcnt[k] = -1; tiles[k] = 0;
                end
                pu_ready = '0;
                mac_done = '0;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (cur_mask[k]) begin
                        if (set_param[k] && !rarm[k]) begin
                            rarm[k] = 1;
                            rcnt[k] = rdy_dly[k];
                        end
                        if (rarm[k] && !pu_ready[k]) begin
                            if (rcnt[k] == 0) pu_ready[k] = 1'b1;
                            else rcnt[k]--;
                        end
                        mac_done[k] = 1'b0;
                        if (start_mac[k]) begin
                            dcnt[k] = (k == late_pu && tiles[k] == late_tile) ? LATE_DLY : done_dly[k];
                            tiles[k]++;
                        end
                        if (dcnt[k] == 0) begin
                            mac_done[k] = 1'b1;
                            dcnt[k] = -1;
                        end else if (dcnt[k] > 0) begin
                            dcnt[k]--;
                        end
                    end else begin
                        pu_ready[k] = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
                        mac_done[k] = noise_en ? ($urandom_range(0, 3) == 0) : 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT starts a tile or finishes a layer.
    initial begin
        int nterm;
        bit setp;
        int last_term;
        start_t s;
        end_t   e;
        nterm = 0; setp = 0; last_term = -10;
        forever begin
            @(negedge clk);
            if (rst) begin
                nterm = 0; setp = 0;
            end else begin
                if (set_param != 4'h0) begin
                    setp = 1;
                    chk("set_param_only_masked", set_param & ~cur_mask, 0);
                end
                if (start_mac != 4'h0) begin
                    if (exp_start.size() == 0) begin
                        chk("unexpected_start_mac", start_mac, 0);
                    end else begin
                        s = exp_start.pop_front();
                        chk("start_mac_bits", start_mac, s.mask);
                        chk("start_tile_idx", tile_idx, s.idx);
                    end
                end
                if (term) begin
                    nterm++;
                    last_term = cyc;
                end
                if (done) begin
                    if (exp_end.size() == 0) begin
                        chk("unexpected_done", done, 0);
                    end else begin
                        e = exp_end.pop_front();
                        chk("done_error", err, e.err);
                        chk("done_tile_idx", tile_idx, e.tile);
                        chk("terminate_count", nterm, e.nterm);
                        chk("set_param_activity", setp, e.setp);
                        chk("starts_missing", exp_start.size(), 0);
                        chk("busy_during_done", busy, 1);
                        if (e.nterm > 0) chk("terminate_precedes_done", last_term, cyc - 1);
                    end
                    exp_start.delete();
                    nterm = 0;
                    setp  = 0;
                end
            end
        end
    end

    task automatic run_layer(input logic [3:0] m, input int cnt, input int ab_tile,
                             input int lt, input int lp, input int rd, input int dd,
                             input bit noise, input bit busy_st);
        int     last;
        bit     e_err;
        int     n;
        int     ab_at;
        bit     term_pending;
        start_t s;
        end_t   e;
        for (int k = 0; k < 4; k++) begin
            rdy_dly[k]  = (rd >= 0) ? rd : int'($urandom_range(0, 4));
            done_dly[k] = (dd >= 0) ? dd : ((ab_tile >= 0) ? int'($urandom_range(4, 8))
                                                           : int'($urandom_range(0, 8)));
        end
        noise_en  = noise;
        late_tile = lt;
        late_pu   = lp;
        if ($urandom_range(0, 2) == 0) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk("idle_abort_ignored", busy, 0);
        end
        chk("error_sticky_in_idle", err, prev_err);
        cur_mask = m;
        // Reference: which tiles start and how the layer ends.
        e_err = 1'b0;
        if (m == 4'h0 || cnt == 0) begin
            e.err = 0; e.nterm = 0; e.tile = 0; e.setp = 0;
        end else begin
            last = cnt - 1;
            if (ab_tile >= 0 && ab_tile < cnt) begin
                last = ab_tile;
            end else if (lt >= 0 && lt < cnt) begin
                last  = lt;
                e_err = 1'b1;
            end
            for (int t = 0; t <= last; t++) begin
                s.mask = m; s.idx = t;
                exp_start.push_back(s);
            end
            e.err = e_err; e.nterm = 1; e.tile = last; e.setp = 1;
        end
        exp_end.push_back(e);
        start     = 1'b1;
        pu_mask   = m;
        num_tiles = 16'(cnt);
        @(negedge clk);
        start     = 1'b0;
        pu_mask   = 4'($urandom);
        num_tiles = 16'($urandom);
        chk("error_cleared_on_start", err, 0);
        if (m == 4'h0 || cnt == 0) chk("zero_layer_done_latency", done, 1);
        n = 0; ab_at = -1; term_pending = 0;
        while (!done && n < 3000) begin
            if (term_pending) begin
                chk("abort_terminate_next_cycle", term, 1);
                term_pending = 0;
            end
            start = 1'b0;
            abort = 1'b0;
            if (ab_tile >= 0 && start_mac != 4'h0 && int'(tile_idx) == ab_tile) ab_at = n + 2;
            if (n == ab_at) begin
                abort = 1'b1;
                term_pending = 1;
            end else if (busy_st && $urandom_range(0, 5) == 0) begin
                start     = 1'b1;
                pu_mask   = 4'($urandom);
                num_tiles = 16'($urandom_range(0, 6));
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        abort = 1'b0;
        chk("layer_completes", done, 1);
        if (!done) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            exp_start.delete();
            exp_end.delete();
            prev_err = 1'b0;
        end else begin
            @(negedge clk);
            chk("busy_low_after_done", busy, 0);
            prev_err = e_err;
        end
    endtask

    task automatic reset_mid_layer();
        start_t s;
        int     n;
        rdy_dly  = '{1, 1, 1, 1};
        done_dly = '{8, 8, 8, 8};
        late_tile = -1;
        noise_en  = 1'b0;
        cur_mask  = 4'hF;
        s.mask = 4'hF; s.idx = 0;
        exp_start.push_back(s);
        start = 1'b1; pu_mask = 4'hF; num_tiles = 16'd4;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (start_mac == 4'h0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reset_test_reached_issue", start_mac, 4'hF);
        // Starts while busy must be ignored.
        start = 1'b1; pu_mask = 4'h3; num_tiles = 16'd1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_ignored_mask", {set_param, start_mac}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("outputs_after_reset", {busy, done, err, tile_idx, set_param, start_mac, term}, 0);
        exp_start.delete();
        exp_end.delete();
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (term || busy) n++;
        end
        chk("quiet_after_reset", n, 0);
        prev_err = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; num_tiles = '0; pu_mask = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, err, tile_idx, set_param, start_mac, term}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_layer(4'hF, 3, -1, -1, 0, 2, 5, 1'b0, 1'b0);
        run_layer(4'b0101, 2, -1, -1, 0, 2, 5, 1'b0, 1'b0);
        run_layer(4'hF, 3, -1, 0, 2, 2, 5, 1'b0, 1'b0);
        run_layer(4'hF, 4, 1, -1, 0, 2, 5, 1'b0, 1'b0);
        run_layer(4'hF, 0, -1, -1, 0, 2, 5, 1'b0, 1'b0);
        run_layer(4'h0, 3, -1, -1, 0, 2, 5, 1'b0, 1'b0);
        reset_mid_layer();

        for (int i = 0; i < 40; i++) begin
            logic [3:0] m;
            int cnt, ab, lt, lp, sel;
            m   = 4'($urandom);
            cnt = int'($urandom_range(0, 5));
            ab  = -1; lt = -1; lp = 0;
            sel = int'($urandom_range(0, 5));
            if (m != 4'h0 && cnt != 0) begin
                if (sel == 0) begin
                    ab = int'($urandom_range(0, cnt - 1));
                end else if (sel == 1) begin
                    lt = int'($urandom_range(0, cnt - 1));
                    lp = int'($urandom_range(0, 3));
                    while (!m[lp]) lp = int'($urandom_range(0, 3));
                end
            end
            run_layer(m, cnt, ab, lt, lp, -1, -1, 1'b1, 1'b1);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
